pwm_ramp_ctrl: RTL and testbench
================================

Name: pwm_ramp_ctrl

Overview:
Soft-start/slew controller that sequences the duty value fed to the team's `dutycycle` PWM block. It accepts a target duty through a valid/ready handshake. It then ramps its `val` output toward that target by a fixed step once every DIV PWM periods. `val` only changes on a PWM period boundary, so the downstream PWM never sees a mid-period glitch.

Parameters:
- CTR, 8, width of the PWM counter and duty value. Must equal the CTR of the driven `dutycycle` instance.
- STEP, 16, duty increment/decrement applied per ramp step. Range 1..2^CTR-1.
- DIV, 1, number of PWM periods per ramp step. Must be ≥1.

Ports:
- clk  input  1  system clock; same clock as the `dutycycle` instance.
- rst  input  1  asynchronous, active-low reset.
- tgt  input  CTR  requested target duty.
- tgt_valid  input  1  tgt is valid this cycle.
- tgt_ready  output  1  controller can accept a target.
- val  output  CTR  duty value; connect to `dutycycle.val`.
- period  output  1  one-cycle strobe on the last cycle of each PWM period.
- busy  output  1  a ramp is in progress.
- done  output  1  one-cycle pulse when val reaches tgt.

Behaviour:
- Reset (rst=0, async) sets:
  - period counter cnt=0, divider div_cnt=0, tgt_reg=0.
  - val=0, state=IDLE.
  - tgt_ready=1, busy=0, done=0, period=0.
- Period counter:
  - cnt is CTR bits, increments every clk and wraps 2^CTR-1 → 0.
  - period is registered: high exactly in the cycles where cnt==2^CTR-1.
  - First period strobe occurs 2^CTR-1 cycles after reset release; it then repeats every 2^CTR cycles.
- Handshake:
  - Accept occurs when tgt_valid && tgt_ready at a rising clk edge.
  - tgt_ready = (state==IDLE).
  - While busy, tgt_valid is ignored and tgt_reg is held.
- FSM states: IDLE, RAMP_UP, RAMP_DOWN.
- IDLE, on accept:
  - tgt_reg ← tgt, div_cnt ← 0.
  - tgt > val → RAMP_UP.
  - tgt < val → RAMP_DOWN.
  - tgt == val → stay IDLE; done=1 in the next cycle.
- RAMP_UP / RAMP_DOWN, on each cycle with period=1:
  - If div_cnt != DIV-1: div_cnt increments, val holds.
  - If div_cnt == DIV-1: div_cnt ← 0 and a step is applied.
- Step arithmetic (CTR+1-bit intermediate; no wrap or overflow permitted):
  - Up: if tgt_reg - val ≤ STEP, val ← tgt_reg; else val ← val + STEP.
  - Down: if val - tgt_reg ≤ STEP, val ← tgt_reg; else val ← val - STEP.
- The step register update lands on the edge ending the cnt==2^CTR-1 cycle. The new val is therefore valid from cnt==0.
- Completion: when a step sets val==tgt_reg:
  - state → IDLE on the same edge, busy falls.
  - done=1 for the following cycle only.
- Latency:
  - Accept in a non-strobe cycle: the first val change lands at the DIV-th period boundary after accept.
  - Accept in a strobe cycle: that strobe is not counted.
- busy = (state != IDLE), registered alongside state.
- Boundaries:
  - tgt=2^CTR-1 ramps cleanly to full scale.
  - tgt=0 ramps cleanly to 0.
  - The final step is always clamped; val never overshoots tgt_reg.
- Reset asserted mid-ramp: val goes to 0 immediately (asynchronous) and the controller returns to IDLE. Any partially completed ramp is discarded.

Test Plan (CTR=8, STEP=16, DIV=1 unless noted):
1. Reset, then release and hold tgt_valid=0.
   - Required: val=0, tgt_ready=1, busy=0.
   - period is first high at cycle 255 after release, then every 256 cycles.
2. From val=0, tgt=128 accepted.
   - Required: busy=1, tgt_ready=0.
   - val steps 16,32,…,128 at 8 consecutive period boundaries.
   - done is a single-cycle pulse after the 128 update; busy=0 and tgt_ready=1 afterward.
3. From val=128, tgt=30.
   - Required: val = 112,96,80,64,48,32,30 over 7 boundaries; the last step is clamped.
   - Then one done pulse; val holds 30.
4. From val=30, tgt=30.
   - Required: no busy; done pulse 1 cycle after accept; val unchanged.
5. During a ramp 0→128, drive tgt_valid=1, tgt=200.
   - Required: tgt_ready=0, request ignored; ramp still ends at 128.
   - With DIV=4, a 0→64 ramp takes exactly 16 periods.
6. Drive rst low mid-ramp, at val=48 heading to 128.
   - Required: val=0 and busy=0 asynchronously, before the next clk edge.
   - After release, cnt restarts from 0.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start / slew controller for the dutycycle PWM block: ramps val toward an
// accepted target in fixed steps, updating only on PWM period boundaries.
module pwm_ramp_ctrl #(
  parameter int CTR  = 8,
  parameter int STEP = 16,
  parameter int DIV  = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [CTR-1:0] tgt,
  input  logic           tgt_valid,
  output logic           tgt_ready,
  output logic [CTR-1:0] val,
  output logic           period,
  output logic           busy,
  output logic           done
);

  localparam int             DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(DIV - 1);
  localparam logic [CTR:0]   STEP_W   = (CTR + 1)'(STEP);
  localparam logic [CTR-1:0] CNT_PRE  = {{(CTR - 1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} state_t;

  state_t         state;
  logic [CTR-1:0] cnt;
  logic [CTR-1:0] tgt_reg;
  logic [DW-1:0]  div_cnt;
  logic [CTR:0]   gap;
  logic [CTR:0]   val_up;
  logic [CTR:0]   val_dn;
  logic [CTR-1:0] step_val;

  // One extra bit keeps the distance and the stepped value free of wrap.
  always_comb begin
    val_up   = {1'b0, val} + STEP_W;
    val_dn   = {1'b0, val} - STEP_W;
    gap      = (state == RAMP_UP) ? ({1'b0, tgt_reg} - {1'b0, val})
                                  : ({1'b0, val} - {1'b0, tgt_reg});
    step_val = tgt_reg;
    if (gap > STEP_W)
      step_val = (state == RAMP_UP) ? val_up[CTR-1:0] : val_dn[CTR-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      period    <= 1'b0;
      div_cnt   <= '0;
      tgt_reg   <= '0;
      val       <= '0;
      state     <= IDLE;
      tgt_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      cnt    <= cnt + 1'b1;
      // Registered strobe lands exactly on the cnt == all-ones cycle.
      period <= (cnt == CNT_PRE);
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (tgt_valid && tgt_ready) begin
            tgt_reg <= tgt;
            div_cnt <= '0;
            if (tgt > val) begin
              state     <= RAMP_UP;
              busy      <= 1'b1;
              tgt_ready <= 1'b0;
            end else if (tgt < val) begin
              state     <= RAMP_DOWN;
              busy      <= 1'b1;
              tgt_ready <= 1'b0;
            end else begin
              done <= 1'b1;
            end
          end
        end
        default: begin
          if (period) begin
            if (div_cnt != DIV_LAST) begin
              div_cnt <= div_cnt + 1'b1;
            end else begin
              div_cnt <= '0;
              val     <= step_val;
              if (step_val == tgt_reg) begin
                state     <= IDLE;
                busy      <= 1'b0;
                tgt_ready <= 1'b1;
                done      <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: strobe timing, ramps up/down with clamping,
// ignored requests while busy, DIV=4 pacing and asynchronous reset mid-ramp.
module tb_pwm_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tgt, tgt2;
  logic       tgt_valid, tgt_valid2;
  logic       tgt_ready, tgt_ready2;
  logic [7:0] val, val2;
  logic       period, period2;
  logic       busy, busy2;
  logic       done, done2;

  int checks   = 0;
  int failures = 0;
  int exp_val  = 0;
  int n, k;
  bit prev_strobe;

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(.CTR(8), .STEP(16), .DIV(1)) u_dut (
    .clk(clk), .rst(rst), .tgt(tgt), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
    .val(val), .period(period), .busy(busy), .done(done)
  );

  pwm_ramp_ctrl #(.CTR(8), .STEP(16), .DIV(4)) u_div4 (
    .clk(clk), .rst(rst), .tgt(tgt2), .tgt_valid(tgt_valid2), .tgt_ready(tgt_ready2),
    .val(val2), .period(period2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_strobe(input string tag);
    int c = 0;
    while (!period && c < 600) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_strobe"}, period, 1);
  endtask

  task automatic accept(input int t);
    tgt       = 8'(t);
    tgt_valid = 1'b1;
    @(negedge clk);
    tgt_valid = 1'b0;
  endtask

  // Steps through every boundary of a ramp, checking hold-before and value-after.
  task automatic ramp(input int t, input string tag, input bit junk);
    int v = exp_val;
    int nv;
    accept(t);
    chk({tag, "_busy_acc"}, busy, 1);
    chk({tag, "_ready_acc"}, tgt_ready, 0);
    chk({tag, "_val_acc"}, val, v);
    if (junk) begin
      tgt       = 8'd200;
      tgt_valid = 1'b1;
    end
    while (v != t) begin
      if (t > v) nv = (t - v <= 16) ? t : v + 16;
      else       nv = (v - t <= 16) ? t : v - 16;
      if (junk && nv == t) tgt_valid = 1'b0;
      wait_strobe(tag);
      chk({tag, "_hold"}, val, v);
      chk({tag, "_ready_busy"}, tgt_ready, 0);
      @(negedge clk);
      chk({tag, "_val"}, val, nv);
      chk({tag, "_done"}, done, (nv == t) ? 1 : 0);
      chk({tag, "_busy"}, busy, (nv == t) ? 0 : 1);
      $display("step %s val=%0d expected=%0d", tag, val, nv);
      v = nv;
    end
    @(negedge clk);
    chk({tag, "_done_single"}, done, 0);
    chk({tag, "_ready_end"}, tgt_ready, 1);
    exp_val = v;
  endtask

  initial begin
    rst = 1'b0; tgt = '0; tgt_valid = 1'b0; tgt2 = '0; tgt_valid2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_val", val, 0);
    chk("rst_ready", tgt_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_period", period, 0);
    rst = 1'b1;

    // 1: strobe timing after release
    n = 0;
    while (!period && n < 300) begin @(negedge clk); n++; end
    chk("first_period_cycle", n, 255);
    @(negedge clk);
    chk("period_one_cycle", period, 0);
    n = 1;
    while (!period && n < 300) begin @(negedge clk); n++; end
    chk("period_interval", n, 256);
    chk("idle_val", val, 0);
    chk("idle_ready", tgt_ready, 1);
    chk("idle_busy", busy, 0);
    @(negedge clk);

    // 2, 3: ramp up then down with clamp
    ramp(128, "up128", 1'b0);
    ramp(30, "dn30", 1'b0);
    repeat (5) @(negedge clk);
    chk("hold30", val, 30);

    // 4: equal target
    accept(30);
    chk("eq_done", done, 1);
    chk("eq_busy", busy, 0);
    chk("eq_val", val, 30);
    @(negedge clk);
    chk("eq_done_single", done, 0);
    $display("equal target val=%0d", val);

    // tgt=0 boundary, then 5: request ignored while busy
    ramp(0, "dn0", 1'b0);
    ramp(128, "junk", 1'b1);
    repeat (3) @(negedge clk);
    chk("junk_final", val, 128);
    chk("junk_idle", busy, 0);

    // full-scale boundary and back to zero
    ramp(255, "up255", 1'b0);
    ramp(0, "dn255", 1'b0);

    // 6: asynchronous reset mid-ramp
    accept(128);
    repeat (3) begin
      wait_strobe("rst_ramp");
      @(negedge clk);
    end
    chk("pre_rst_val", val, 48);
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("async_val", val, 0);
    chk("async_busy", busy, 0);
    chk("async_ready", tgt_ready, 1);
    $display("async reset val=%0d busy=%0d", val, busy);
    @(negedge clk);
    rst = 1'b1;
    exp_val = 0;
    n = 0;
    while (!period && n < 300) begin @(negedge clk); n++; end
    chk("rst_cnt_restart", n, 255);
    chk("post_rst_val", val, 0);

    // DIV=4: 0 -> 64 takes 16 periods
    tgt2 = 8'd64;
    tgt_valid2 = 1'b1;
    @(negedge clk);
    tgt_valid2 = 1'b0;
    chk("div4_busy", busy2, 1);
    k = 0;
    prev_strobe = 1'b0;
    n = 0;
    while (!done2 && n < 6000) begin
      @(negedge clk);
      n++;
      if (prev_strobe) begin
        k++;
        if (k == 3) chk("div4_hold3", val2, 0);
        if (k == 4) chk("div4_step4", val2, 16);
      end
      prev_strobe = period2;
    end
    chk("div4_periods", k, 16);
    chk("div4_val", val2, 64);
    chk("div4_done", done2, 1);
    chk("div4_idle", busy2, 0);
    $display("div4 ramp periods=%0d val=%0d", k, val2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
